// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial sequence detector.
//
// Shifts accepted bits of a 1-bit stream into a PAT_W-deep history and flags
// every cycle where the newest PAT_W accepted bits equal PATTERN. Bit PAT_W-1
// of PATTERN is the oldest bit and bit 0 the most recent one.
//
// The shift/compare form is used directly. A KMP-fallback FSM over S0..S_PAT_W
// would be cycle-identical, but the compare needs no fallback table.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in         serial data bit
//   in_valid   'in' is accepted only when high
//   cnt_clr    synchronous clear of match_cnt and cnt_sat (lower priority than rst)
//   out        one-cycle match pulse (same cycle if MOORE=0, one cycle later if MOORE=1)
//   match_cnt  saturating count of matches since reset or clear
//   cnt_sat    sticky flag, set once match_cnt reaches all-ones
module seq_detect_param #(
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     PATTERN = 4'b1011,
  parameter bit                   OVERLAP = 1'b1,
  parameter bit                   MOORE   = 1'b0,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned      FillW    = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  logic [PAT_W-1:0] hist_q, hist_d, hist_acc;
  logic [FillW-1:0] fill_q, fill_d, fill_acc;
  logic             out_q, out_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             cnt_sat_q, cnt_sat_d;
  logic             hit;

  // History update and match compare.
  always_comb begin
    hist_acc = hist_q;
    fill_acc = fill_q;
    if (in_valid) begin
      hist_acc = {hist_q[PAT_W-2:0], in};
      fill_acc = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);
    end

    // The fill check keeps zeros left over from reset from aliasing a match.
    hit = in_valid & (fill_acc == FillFull) & (hist_acc == PATTERN);

    hist_d = hist_acc;
    fill_d = fill_acc;
    if (hit && !OVERLAP) begin
      // Non-overlapping: the next match must be built from PAT_W fresh bits.
      hist_d = '0;
      fill_d = '0;
    end

    out_d = hit;
  end

  // Saturating match counter; cnt_clr wins over a same-cycle hit.
  always_comb begin
    match_cnt_d = match_cnt_q;
    cnt_sat_d   = cnt_sat_q;
    if (cnt_clr) begin
      match_cnt_d = '0;
      cnt_sat_d   = 1'b0;
    end else begin
      if (hit && (match_cnt_q != CntMax)) begin
        match_cnt_d = match_cnt_q + CNT_W'(1);
      end
      if (match_cnt_d == CntMax) begin
        cnt_sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q      <= '0;
      fill_q      <= '0;
      out_q       <= 1'b0;
      match_cnt_q <= '0;
      cnt_sat_q   <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
      match_cnt_q <= match_cnt_d;
      cnt_sat_q   <= cnt_sat_d;
    end
  end

  // Output is held low during reset in both timing modes.
  always_comb begin
    out = MOORE ? (out_q & ~rst) : (hit & ~rst);
  end

  assign match_cnt = match_cnt_q;
  assign cnt_sat   = cnt_sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: five instances with different OVERLAP/MOORE/CNT_W
// settings share one stimulus stream; each is compared against a window/count
// reference model every cycle, plus directed checks on the documented scenarios.
module tb_seq_detect_param;

  localparam int N = 5;
  // Instance g: OVERLAP = OVS[g], MOORE = MOS[g], CNT_W = cw_of(g).
  localparam logic [N-1:0] OVS = 5'b01101;
  localparam logic [N-1:0] MOS = 5'b10100;
  localparam int unsigned PAT = 11;  // 4'b1011
  localparam int unsigned PW  = 4;

  function automatic int unsigned cw_of(input int g);
    case (g)
      3:       return 2;
      4:       return 3;
      default: return 8;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst, din, in_valid, cnt_clr;
  logic [N-1:0] out_obs, sat_obs;
  logic [31:0]  cnt_obs [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned CW = cw_of(g);
    logic [CW-1:0] cnt;
    seq_detect_param #(
      .PAT_W   (4),
      .PATTERN (4'b1011),
      .OVERLAP (OVS[g]),
      .MOORE   (MOS[g]),
      .CNT_W   (CW)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in        (din),
      .in_valid  (in_valid),
      .cnt_clr   (cnt_clr),
      .out       (out_obs[g]),
      .match_cnt (cnt),
      .cnt_sat   (sat_obs[g])
    );
    assign cnt_obs[g] = 32'(cnt);
  end

  // Reference model: window = value of the last accepted bits, len = how many held.
  int unsigned win_m [N];
  int unsigned len_m [N];
  int unsigned cnt_m [N];
  bit          sat_m [N];
  bit          prev_m[N];
  bit          primed = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit b, input bit v, input bit c);
    bit          hit [N];
    int unsigned nwin[N];
    int unsigned nlen[N];
    bit          exp_out;
    int unsigned cmax;
    @(negedge clk);
    rst = r; din = b; in_valid = v; cnt_clr = c;
    #1;
    for (int g = 0; g < N; g++) begin
      nwin[g] = win_m[g];
      nlen[g] = len_m[g];
      hit[g]  = 1'b0;
      if (v) begin
        nwin[g] = (win_m[g] * 2 + b) % 16;
        nlen[g] = (len_m[g] + 1 > PW) ? PW : len_m[g] + 1;
        hit[g]  = (nlen[g] == PW) && (nwin[g] == PAT);
      end
      if (r) exp_out = 1'b0;
      else   exp_out = MOS[g] ? prev_m[g] : hit[g];
      chk($sformatf("out[%0d]", g), {31'd0, out_obs[g]}, {31'd0, exp_out});
      if (primed) begin
        chk($sformatf("match_cnt[%0d]", g), cnt_obs[g], cnt_m[g]);
        chk($sformatf("cnt_sat[%0d]", g), {31'd0, sat_obs[g]}, {31'd0, sat_m[g]});
      end
    end
    @(posedge clk);
    for (int g = 0; g < N; g++) begin
      cmax = (1 << cw_of(g)) - 1;
      if (r) begin
        win_m[g] = 0; len_m[g] = 0; cnt_m[g] = 0; sat_m[g] = 1'b0; prev_m[g] = 1'b0;
      end else begin
        if (hit[g] && !OVS[g]) begin
          win_m[g] = 0; len_m[g] = 0;
        end else begin
          win_m[g] = nwin[g]; len_m[g] = nlen[g];
        end
        if (c) begin
          cnt_m[g] = 0; sat_m[g] = 1'b0;
        end else begin
          if (hit[g] && cnt_m[g] < cmax) cnt_m[g]++;
          if (cnt_m[g] == cmax) sat_m[g] = 1'b1;
        end
        prev_m[g] = hit[g];
      end
    end
    primed = 1'b1;
  endtask

  task automatic bits(input logic [15:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, seq[i], 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("reset_cnt0", cnt_obs[0], 32'd0);
    chk("reset_sat3", {31'd0, sat_obs[3]}, 32'd0);

    // Overlap vs non-overlap on 1,0,1,1,0,1,1.
    bits(16'b1011011, 7);
    #1;
    chk("t1_cnt_overlap", cnt_obs[0], 32'd2);
    chk("t2_cnt_nonoverlap", cnt_obs[1], 32'd1);
    bits(16'b1011, 4);
    #1;
    chk("t2_cnt_nonoverlap_again", cnt_obs[1], 32'd2);

    // Moore timing on a fresh 1,0,1,1.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    bits(16'b1011, 4);
    #1;
    chk("t3_cnt_moore", cnt_obs[2], 32'd1);
    chk("t3_out_moore_late", {31'd0, out_obs[2]}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Partial match discarded by reset, then completed with fresh bits.
    bits(16'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    bits(16'b1011, 4);

    // Invalid gap with in=1 must not shift or match.
    bits(16'b10, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    bits(16'b11, 2);

    // Counter saturation with CNT_W=2, then clear colliding with a hit.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    bits(16'b1011011011011, 13);
    #1;
    chk("t6_cnt_sat_value", cnt_obs[3], 32'd3);
    chk("t6_sat_flag", {31'd0, sat_obs[3]}, 32'd1);
    chk("t6_cnt_wide", cnt_obs[0], 32'd4);
    bits(16'b01, 2);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("t6_clr_cnt", cnt_obs[3], 32'd0);
    chk("t6_clr_sat", {31'd0, sat_obs[3]}, 32'd0);

    // Random traffic with occasional reset and clear.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
